bp_l15_req_sched: RTL and testbench

BP_L15_REQ_SCHED -- requirements
Module: bp_l15_req_sched

---
 rtl/bp_l15_req_sched.sv | 186 ++++++++++++++++++
 tb/tb_bp_l15_req_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_l15_req_sched.sv
// L1.5 request scheduler: arbitrates a load and a store requester onto the
// single-outstanding L1.5 transducer interface (IDLE -> ISSUE -> WAIT).
// Optional WAIT-state watchdog is enabled by defining BP_L15_SCHED_TIMEOUT_EN.
module bp_l15_req_sched #(
    parameter int unsigned paddr_width_p    = 40,
    parameter int unsigned timeout_cycles_p = 1023
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     ld_v_i,
    input  logic [paddr_width_p-1:0] ld_addr_i,
    input  logic [2:0]               ld_size_i,
    input  logic                     ld_nc_i,
    output logic                     ld_yumi_o,

    input  logic                     st_v_i,
    input  logic [paddr_width_p-1:0] st_addr_i,
    input  logic [2:0]               st_size_i,
    input  logic [63:0]              st_data_i,
    input  logic                     st_nc_i,
    output logic                     st_yumi_o,

    output logic                     transducer_l15_val,
    output logic [4:0]               transducer_l15_rqtype,
    output logic [2:0]               transducer_l15_size,
    output logic [paddr_width_p-1:0] transducer_l15_address,
    output logic [63:0]              transducer_l15_data,
    output logic                     transducer_l15_nc,
    input  logic                     l15_transducer_ack,

    input  logic                     l15_transducer_val,
    input  logic [3:0]               l15_transducer_returntype,
    output logic                     transducer_l15_req_ack,

    output logic                     ld_resp_v_o,
    output logic                     st_resp_v_o,
    output logic                     timeout_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [4:0] RqLoad  = 5'b00000;
    localparam logic [4:0] RqStore = 5'b00001;
    localparam logic [3:0] RtLoad  = 4'b0000;
    localparam logic [3:0] RtStore = 4'b0100;

    state_e state_q, state_d;

    // Captured request; favour_st_q set means store wins the next tie.
    logic                     req_is_st_q;
    logic [paddr_width_p-1:0] req_addr_q;
    logic [2:0]               req_size_q;
    logic [63:0]              req_data_q;
    logic                     req_nc_q;
    logic                     favour_st_q;

    logic grant_ld, grant_st, resp_match;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_ld || grant_st) state_d = StIssue;
            StIssue: if (l15_transducer_ack)   state_d = StWait;
            StWait:  if (resp_match)           state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Grants, L1.5 request drive and response handling; everything is forced
    // low while reset is asserted.
    always_comb begin
        grant_st   = 1'b0;
        grant_ld   = 1'b0;
        resp_match = 1'b0;

        transducer_l15_val     = 1'b0;
        transducer_l15_rqtype  = '0;
        transducer_l15_size    = '0;
        transducer_l15_address = '0;
        transducer_l15_data    = '0;
        transducer_l15_nc      = 1'b0;
        transducer_l15_req_ack = 1'b0;

        if (!reset_i) begin
            if (state_q == StIdle) begin
                grant_st = st_v_i && (!ld_v_i || favour_st_q);
                grant_ld = ld_v_i && !(st_v_i && favour_st_q);
            end

            // Only a response whose type matches the outstanding request
            // completes it; anything else is acked and dropped.
            if (state_q == StWait && l15_transducer_val) begin
                resp_match = req_is_st_q ? (l15_transducer_returntype == RtStore)
                                         : (l15_transducer_returntype == RtLoad);
            end

            transducer_l15_val     = (state_q == StIssue);
            transducer_l15_rqtype  = req_is_st_q ? RqStore : RqLoad;
            transducer_l15_size    = req_size_q;
            transducer_l15_address = req_addr_q;
            transducer_l15_data    = req_data_q;
            transducer_l15_nc      = req_nc_q;
            transducer_l15_req_ack = l15_transducer_val;
        end

        ld_yumi_o   = grant_ld;
        st_yumi_o   = grant_st;
        ld_resp_v_o = resp_match && !req_is_st_q;
        st_resp_v_o = resp_match &&  req_is_st_q;
    end

    // Capture the granted request and advance the round-robin pointer
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            req_is_st_q <= 1'b0;
            req_addr_q  <= '0;
            req_size_q  <= '0;
            req_data_q  <= '0;
            req_nc_q    <= 1'b0;
            favour_st_q <= 1'b0;
        end else if (grant_ld) begin
            req_is_st_q <= 1'b0;
            req_addr_q  <= ld_addr_i;
            req_size_q  <= ld_size_i;
            req_data_q  <= '0;
            req_nc_q    <= ld_nc_i;
            favour_st_q <= 1'b1;
        end else if (grant_st) begin
            req_is_st_q <= 1'b1;
            req_addr_q  <= st_addr_i;
            req_size_q  <= st_size_i;
            req_data_q  <= st_data_i;
            req_nc_q    <= st_nc_i;
            favour_st_q <= 1'b0;
        end
    end

`ifdef BP_L15_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = (timeout_cycles_p < 1) ? 1 : $clog2(timeout_cycles_p + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(timeout_cycles_p);

    logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    // Watchdog: count WAIT cycles (saturating), flag sticks until reset
    always_comb begin
        wd_cnt_d  = '0;
        timeout_d = timeout_q;
        if (state_q == StWait && !resp_match) begin
            wd_cnt_d = (wd_cnt_q == CntMax) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
        if (wd_cnt_d == CntMax && state_q == StWait) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q && !reset_i;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (timeout_cycles_p != 0);
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_l15_req_sched.sv
// Directed self-checking bench for bp_l15_req_sched.
module tb_bp_l15_req_sched;

    localparam int unsigned AW = 40;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          ld_v_i, ld_nc_i, st_v_i, st_nc_i;
    logic [AW-1:0] ld_addr_i, st_addr_i;
    logic [2:0]    ld_size_i, st_size_i;
    logic [63:0]   st_data_i;
    logic          ld_yumi_o, st_yumi_o;
    logic          transducer_l15_val, transducer_l15_nc;
    logic [4:0]    transducer_l15_rqtype;
    logic [2:0]    transducer_l15_size;
    logic [AW-1:0] transducer_l15_address;
    logic [63:0]   transducer_l15_data;
    logic          l15_transducer_ack, l15_transducer_val;
    logic [3:0]    l15_transducer_returntype;
    logic          transducer_l15_req_ack, ld_resp_v_o, st_resp_v_o, timeout_o;

    int checks = 0;
    int failures = 0;

    bp_l15_req_sched #(
        .paddr_width_p   (AW),
        .timeout_cycles_p(16)
    ) dut (
        .clk_i                    (clk_i),
        .reset_i                  (reset_i),
        .ld_v_i                   (ld_v_i),
        .ld_addr_i                (ld_addr_i),
        .ld_size_i                (ld_size_i),
        .ld_nc_i                  (ld_nc_i),
        .ld_yumi_o                (ld_yumi_o),
        .st_v_i                   (st_v_i),
        .st_addr_i                (st_addr_i),
        .st_size_i                (st_size_i),
        .st_data_i                (st_data_i),
        .st_nc_i                  (st_nc_i),
        .st_yumi_o                (st_yumi_o),
        .transducer_l15_val       (transducer_l15_val),
        .transducer_l15_rqtype    (transducer_l15_rqtype),
        .transducer_l15_size      (transducer_l15_size),
        .transducer_l15_address   (transducer_l15_address),
        .transducer_l15_data      (transducer_l15_data),
        .transducer_l15_nc        (transducer_l15_nc),
        .l15_transducer_ack       (l15_transducer_ack),
        .l15_transducer_val       (l15_transducer_val),
        .l15_transducer_returntype(l15_transducer_returntype),
        .transducer_l15_req_ack   (transducer_l15_req_ack),
        .ld_resp_v_o              (ld_resp_v_o),
        .st_resp_v_o              (st_resp_v_o),
        .timeout_o                (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        ld_v_i = 0; ld_addr_i = '0; ld_size_i = 0; ld_nc_i = 0;
        st_v_i = 0; st_addr_i = '0; st_size_i = 0; st_data_i = '0; st_nc_i = 0;
        l15_transducer_ack = 0; l15_transducer_val = 0; l15_transducer_returntype = 0;
    endtask

    task automatic do_reset();
        reset_i = 1;
        cyc();
        cyc();
        reset_i = 0;
    endtask

    // One full transaction from the IDLE cycle, expecting the given grant.
    task automatic rr_txn(input string tag, input logic exp_st);
        #1;
        chk({tag, "_ld_yumi"}, 64'(ld_yumi_o), 64'(!exp_st));
        chk({tag, "_st_yumi"}, 64'(st_yumi_o), 64'(exp_st));
        cyc();
        #1;
        chk({tag, "_rqtype"}, 64'(transducer_l15_rqtype), exp_st ? 64'd1 : 64'd0);
        chk({tag, "_addr"}, 64'(transducer_l15_address), exp_st ? 64'h200 : 64'h100);
        chk({tag, "_issue_yumi"}, 64'(ld_yumi_o | st_yumi_o), 64'd0);
        l15_transducer_ack = 1;
        cyc();
        l15_transducer_ack = 0;
        l15_transducer_val = 1;
        l15_transducer_returntype = exp_st ? 4'b0100 : 4'b0000;
        #1;
        chk({tag, "_resp"}, 64'({ld_resp_v_o, st_resp_v_o}), exp_st ? 64'b01 : 64'b10);
        cyc();
        l15_transducer_val = 0;
    endtask

    initial begin
        clear_inputs();
        // Reset with live requests and a stray response: all outputs low.
        reset_i = 1; ld_v_i = 1; st_v_i = 1; l15_transducer_val = 1;
        #1;
        chk("rst_yumi", 64'({ld_yumi_o, st_yumi_o}), 64'd0);
        chk("rst_req_ack", 64'(transducer_l15_req_ack), 64'd0);
        chk("rst_val", 64'(transducer_l15_val), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        cyc();
        cyc();
        reset_i = 0;
        clear_inputs();
        #1;
        chk("post_rst_outs", 64'({transducer_l15_val, ld_yumi_o, st_yumi_o, ld_resp_v_o,
                                  st_resp_v_o, transducer_l15_req_ack}), 64'd0);
        cyc();

        // Single load.
        ld_v_i = 1; ld_addr_i = 40'h80001000; ld_size_i = 3;
        #1;
        chk("ld_yumi", 64'(ld_yumi_o), 64'd1);
        chk("ld_st_yumi", 64'(st_yumi_o), 64'd0);
        cyc();
        ld_v_i = 0;
        #1;
        chk("ld_val", 64'(transducer_l15_val), 64'd1);
        chk("ld_rqtype", 64'(transducer_l15_rqtype), 64'd0);
        chk("ld_addr", 64'(transducer_l15_address), 64'h80001000);
        chk("ld_size", 64'(transducer_l15_size), 64'd3);
        chk("ld_data", transducer_l15_data, 64'd0);
        l15_transducer_ack = 1;
        cyc();
        l15_transducer_ack = 0;
        #1;
        chk("ld_wait_val", 64'(transducer_l15_val), 64'd0);
        l15_transducer_val = 1; l15_transducer_returntype = 4'b0000;
        #1;
        chk("ld_req_ack", 64'(transducer_l15_req_ack), 64'd1);
        chk("ld_resp", 64'({ld_resp_v_o, st_resp_v_o}), 64'b10);
        cyc();
        l15_transducer_val = 0;

        // Round-robin with both requesters held, starting from reset.
        do_reset();
        ld_v_i = 1; ld_addr_i = 40'h100; st_v_i = 1; st_addr_i = 40'h200;
        rr_txn("rr0", 1'b0);
        rr_txn("rr1", 1'b1);
        rr_txn("rr2", 1'b0);
        clear_inputs();

        // Store with a 5-cycle ack delay; fields must hold while source changes.
        st_v_i = 1; st_addr_i = 40'h12345678; st_size_i = 3;
        st_data_i = 64'hDEADBEEF_CAFEF00D; st_nc_i = 1;
        #1;
        chk("st_yumi", 64'(st_yumi_o), 64'd1);
        cyc();
        st_v_i = 0; st_data_i = 64'h0; st_addr_i = '0; st_nc_i = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i == 0 || i == 5) begin
                chk("st_val", 64'(transducer_l15_val), 64'd1);
                chk("st_rqtype", 64'(transducer_l15_rqtype), 64'd1);
                chk("st_data", transducer_l15_data, 64'hDEADBEEF_CAFEF00D);
                chk("st_addr", 64'(transducer_l15_address), 64'h12345678);
                chk("st_nc", 64'(transducer_l15_nc), 64'd1);
            end
            if (i == 5) l15_transducer_ack = 1;
            cyc();
        end
        l15_transducer_ack = 0;
        #1;
        chk("st_wait_val", 64'(transducer_l15_val), 64'd0);
        l15_transducer_val = 1; l15_transducer_returntype = 4'b0100;
        #1;
        chk("st_resp", 64'({ld_resp_v_o, st_resp_v_o}), 64'b01);
        cyc();
        l15_transducer_val = 0;

        // Load: response coincident with ack is dropped; stray type in WAIT dropped.
        ld_v_i = 1; ld_addr_i = 40'h300;
        cyc();
        ld_v_i = 0;
        l15_transducer_ack = 1; l15_transducer_val = 1; l15_transducer_returntype = 4'b0000;
        #1;
        chk("issue_resp_drop", 64'({ld_resp_v_o, transducer_l15_req_ack}), 64'b01);
        cyc();
        l15_transducer_ack = 0; l15_transducer_returntype = 4'b0011; ld_v_i = 1;
        #1;
        chk("stray_ack", 64'(transducer_l15_req_ack), 64'd1);
        chk("stray_resp", 64'({ld_resp_v_o, st_resp_v_o}), 64'd0);
        cyc();
        l15_transducer_val = 0;
        #1;
        chk("stray_still_wait", 64'({ld_yumi_o, transducer_l15_val}), 64'd0);
        l15_transducer_val = 1; l15_transducer_returntype = 4'b0000;
        #1;
        chk("stray_then_ld", 64'(ld_resp_v_o), 64'd1);
        cyc();
        clear_inputs();

        // Reset during ISSUE abandons the request.
        ld_v_i = 1; ld_addr_i = 40'h400;
        cyc();
        ld_v_i = 0;
        #1;
        chk("pre_rst_val", 64'(transducer_l15_val), 64'd1);
        reset_i = 1;
        #1;
        chk("mid_rst_val", 64'(transducer_l15_val), 64'd0);
        cyc();
        reset_i = 0;
        #1;
        chk("after_rst_outs", 64'({transducer_l15_val, ld_resp_v_o, st_resp_v_o}), 64'd0);
        ld_v_i = 1;
        #1;
        chk("after_rst_idle", 64'(ld_yumi_o), 64'd1);
        cyc();
        ld_v_i = 0;
        l15_transducer_ack = 1;
        cyc();
        l15_transducer_ack = 0;

        // Sit in WAIT with no response: k counts cycles since WAIT entry.
        for (int k = 0; k <= 20; k++) begin
            #1;
            if (k == 0 || k == 15 || k == 16 || k == 20) begin
`ifdef BP_L15_SCHED_TIMEOUT_EN
                chk("timeout", 64'(timeout_o), (k >= 16) ? 64'd1 : 64'd0);
`else
                chk("timeout_off", 64'(timeout_o), 64'd0);
`endif
            end
            cyc();
        end
        do_reset();
        #1;
        chk("timeout_cleared", 64'(timeout_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
